fetch_queue_unit: RTL and testbench

//  Parametrised successor of the fetch stage. Owns the PC and issues in-order requests to

---
 rtl/fetch_queue_unit_pkg.sv | 15 +
 rtl/fetch_queue_unit_fifo.sv | 58 +++++
 rtl/fetch_queue_unit.sv | 102 ++++++++++
 tb/tb_fetch_queue_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and helpers for the fetch queue unit and later pipeline stages.
package fetch_queue_unit_pkg;

    // Byte distance between consecutive sequential fetch addresses.
    localparam int unsigned PC_STEP = 4;

    // Canonical RISC-V NOP (addi x0, x0, 0); later stages insert it as a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Width of a counter able to hold the values 0..d inclusive.
    function automatic int unsigned fetch_cnt_w(input int unsigned d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO with flush, used as the fetched-instruction queue.
// Read data is the head entry (first-word-fall-through).
// The caller never pushes when full unless it also pops in the same cycle.
module fetch_queue_unit_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 wdata,
    output logic [WIDTH-1:0]                 rdata,
    output logic                             full,
    output logic                             empty,
    output logic [fetch_cnt_w(DEPTH)-1:0]    count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = fetch_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH[CntW-1:0]);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests and queues returned
// instructions with their PCs for decode. A redirect flushes the queue and
// discards every response still in flight at that point.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     ILEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    input  logic            dec_ready
);

    localparam int unsigned     CntW     = fetch_cnt_w(DEPTH);
    localparam logic [CntW:0]   DepthLim = DEPTH[CntW:0];
    localparam logic [XLEN-1:0] Step     = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] out_q, out_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] count;
    logic [CntW:0]   in_use;
    logic [XLEN-1:0] target;
    logic            full, empty;
    logic            accept, keep, push, pop;
    logic [XLEN+ILEN-1:0] head;

    // Queued entries plus in-flight requests bound issue, so every response fits.
    assign in_use         = {1'b0, count} + {1'b0, out_q};
    assign imem_req_valid = rst && !redirect_valid && (in_use < DepthLim);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign keep   = imem_rsp_valid && (drop_q == '0);
    assign pop    = dec_valid && dec_ready && !redirect_valid;
    assign push   = keep && !redirect_valid && (!full || pop);
    assign target = redirect_addr & ~XLEN'(3);

    // Next-state for PC, response tag and the in-flight/drop counters.
    always_comb begin
        out_d    = out_q + CntW'(accept) - CntW'(imem_rsp_valid);
        pc_d     = accept ? pc_q + Step : pc_q;
        rsp_pc_d = push ? rsp_pc_q + Step : rsp_pc_q;
        drop_d   = (imem_rsp_valid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
        if (redirect_valid) begin
            pc_d     = target;
            rsp_pc_d = target;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_d   = out_d;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= RESET_VECTOR;
            rsp_pc_q <= RESET_VECTOR;
            out_q    <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue_unit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({rsp_pc_q, imem_rsp_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign dec_valid = rst && !empty;
    assign dec_pc    = head[ILEN +: XLEN];
    assign dec_instr = head[ILEN-1:0];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a fixed-latency in-order imem model.
module tb_fetch_queue_unit;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int lat = 1;
    int acc_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .XLEN         (32),
        .ILEN         (32),
        .DEPTH        (4),
        .RESET_VECTOR (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

    // Instruction memory: records accepted requests, answers 'lat' edges later in order.
    always @(posedge clk) begin
        if (!rst) begin
            pend.delete();
            acc_cnt = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + lat});
            acc_cnt++;
        end
        cyc++;
        #1;
        if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].addr ^ KEY;
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_dec(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, dec_valid}, 32'd1);
        check({tag, "_pc"}, dec_pc, pc);
        check({tag, "_instr"}, dec_instr, pc ^ KEY);
    endtask

    // Steps until dec_valid rises or the budget runs out (timeout shows up as a failed check).
    task automatic wait_dec(input int bound);
        for (int i = 0; i < bound && !dec_valid; i++) step();
    endtask

    // Holds reset for n edges; returns just after release, before the first active edge.
    task automatic do_reset(input int n, input int l, input logic dr);
        rst = 1'b0;
        redirect_valid = 1'b0;
        lat = l;
        dec_ready = dr;
        repeat (n) step();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // 1: reset and first requests
        lat = 1;
        repeat (3) begin
            step();
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        end
        rst = 1'b1;
        #1;
        check("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t1_addr0", imem_req_addr, 32'h100);
        step();
        check("t1_addr1", imem_req_addr, 32'h104);
        check("t1_dec_empty", {31'b0, dec_valid}, 32'd0);
        // 2: sustained stream, one instruction per cycle
        step();
        check("t1_addr2", imem_req_addr, 32'h108);
        check_dec("t2_d0", 32'h100);
        step();
        check_dec("t2_d1", 32'h104);
        step();
        check_dec("t2_d2", 32'h108);
        step();
        check_dec("t2_d3", 32'h10C);

        // 3: decode backpressure fills the queue, then drains in order
        do_reset(2, 1, 1'b0);
        repeat (4) step();
        check("t3_stop_issue", {31'b0, imem_req_valid}, 32'd0);
        repeat (4) step();
        check("t3_accepts", acc_cnt, 32'd4);
        check("t3_full_no_req", {31'b0, imem_req_valid}, 32'd0);
        check_dec("t3_hold", 32'h100);
        dec_ready = 1'b1;
        step();
        check_dec("t3_d1", 32'h104);
        check("t3_resume_req", {31'b0, imem_req_valid}, 32'd1);
        check("t3_resume_addr", imem_req_addr, 32'h110);
        step();
        check_dec("t3_d2", 32'h108);
        step();
        check_dec("t3_d3", 32'h10C);
        step();
        check_dec("t3_d4", 32'h110);

        // 4: redirect with two requests in flight, misaligned target
        do_reset(2, 3, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h2002;
        #1;
        check("t4_no_issue", {31'b0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t4_addr", imem_req_addr, 32'h2000);
        check("t4_dec_empty", {31'b0, dec_valid}, 32'd0);
        wait_dec(12);
        check_dec("t4_first", 32'h2000);
        step();
        check_dec("t4_second", 32'h2004);

        // 5: redirect coinciding with a response and a decode handshake
        do_reset(2, 3, 1'b1);
        repeat (4) step();
        check_dec("t5_pre0", 32'h100);
        step();
        check_dec("t5_pre1", 32'h104);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h500;
        #1;
        check("t5_no_issue", {31'b0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t5_flushed", {31'b0, dec_valid}, 32'd0);
        check("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t5_addr", imem_req_addr, 32'h500);
        wait_dec(12);
        check_dec("t5_first", 32'h500);
        step();
        check_dec("t5_second", 32'h504);

        // 6: back-to-back redirects, the later one wins
        do_reset(2, 3, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h300;
        step();
        redirect_addr  = 32'h400;
        #1;
        check("t6_no_issue", {31'b0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t6_addr", imem_req_addr, 32'h400);
        wait_dec(12);
        check_dec("t6_first", 32'h400);
        step();
        check_dec("t6_second", 32'h404);

        // reset mid-stream clears the queue
        rst = 1'b0;
        step();
        check("rst_mid_dec", {31'b0, dec_valid}, 32'd0);
        check("rst_mid_req", {31'b0, imem_req_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
